// File: rtl/sdram_arb.sv
// Two-port round-robin arbiter in front of a single-command SDRAM controller.
// Port A is the CPU side and port B is the DMA/video side. One access is in flight at a time.
module sdram_arb #(
   parameter int BUSY_TMO = 8,
   parameter int DATA_W   = 32
) (
   input  logic              SDRAM_CLK,
   input  logic              SDRAM_RESn,

   input  logic              A_REQ,
   input  logic              A_WE,
   input  logic [24:0]       A_ADDR,
   input  logic [DATA_W-1:0] A_DIN,
   input  logic [3:0]        A_BE,
   output logic              A_ACK,
   output logic [DATA_W-1:0] A_DOUT,

   input  logic              B_REQ,
   input  logic              B_WE,
   input  logic [24:0]       B_ADDR,
   input  logic [DATA_W-1:0] B_DIN,
   input  logic [3:0]        B_BE,
   output logic              B_ACK,
   output logic [DATA_W-1:0] B_DOUT,

   output logic              SDRAM_RD,
   output logic              SDRAM_WE,
   output logic [24:0]       SDRAM_RADDR,
   output logic [24:0]       SDRAM_WADDR,
   output logic [DATA_W-1:0] SDRAM_DIN,
   output logic [3:0]        SDRAM_BE,
   input  logic              SDRAM_RD_RDY,
   input  logic              SDRAM_WE_RDY,
   input  logic [DATA_W-1:0] SDRAM_DOUT
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

   localparam logic [3:0] TMO_LAST = 4'(BUSY_TMO - 1);

   state_t            state_q;
   port_t             last_grant_q;
   port_t             gnt_port_q;
   logic              gnt_we_q;
   logic [24:0]       gnt_addr_q;
   logic [DATA_W-1:0] gnt_din_q;
   logic [3:0]        gnt_be_q;
   logic [3:0]        tmo_cnt_q;
   logic              a_ack_q;
   logic              b_ack_q;
   logic              rd_q;
   logic              we_q;
   logic [DATA_W-1:0] a_dout_q;
   logic [DATA_W-1:0] b_dout_q;

   logic              a_req_eff;
   logic              b_req_eff;
   logic              sel_valid;
   port_t             sel_port;
   logic              sel_we;
   logic [24:0]       sel_addr;
   logic [DATA_W-1:0] sel_din;
   logic [3:0]        sel_be;
   logic              sel_rdy;
   logic              cur_rdy;

   // A requester that is being acknowledged this cycle is still holding REQ; ignore it once.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      a_req_eff = A_REQ & ~a_ack_q;
      b_req_eff = B_REQ & ~b_ack_q;
      sel_valid = a_req_eff | b_req_eff;
      sel_port  = PORT_A;
      if (a_req_eff && b_req_eff) begin
         sel_port = (last_grant_q == PORT_B) ? PORT_A : PORT_B;
      end else if (b_req_eff) begin
         sel_port = PORT_B;
      end

      sel_we   = A_WE;
      sel_addr = A_ADDR;
      sel_din  = A_DIN;
      sel_be   = A_BE;
      if (sel_port == PORT_B) begin
         sel_we   = B_WE;
         sel_addr = B_ADDR;
         sel_din  = B_DIN;
         sel_be   = B_BE;
      end

      sel_rdy = sel_we   ? SDRAM_WE_RDY : SDRAM_RD_RDY;
      cur_rdy = gnt_we_q ? SDRAM_WE_RDY : SDRAM_RD_RDY;
   end

   always_ff @(posedge SDRAM_CLK or negedge SDRAM_RESn) begin
      if (!SDRAM_RESn) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_B;
         gnt_port_q   <= PORT_A;
         gnt_we_q     <= 1'b0;
         gnt_addr_q   <= '0;
         gnt_din_q    <= '0;
         gnt_be_q     <= '0;
         tmo_cnt_q    <= '0;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         rd_q         <= 1'b0;
         we_q         <= 1'b0;
         a_dout_q     <= '0;
         b_dout_q     <= '0;
      end else begin
         // NOTE: non-blocking everywhere here, so every branch reads the pre-edge values.
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         rd_q    <= 1'b0;
         we_q    <= 1'b0;

         case (state_q)
            IDLE: begin
               if (sel_valid && sel_rdy) begin
                  gnt_port_q   <= sel_port;
                  last_grant_q <= sel_port;
                  gnt_we_q     <= sel_we;
                  gnt_addr_q   <= sel_addr;
                  gnt_din_q    <= sel_din;
                  gnt_be_q     <= sel_be;
                  rd_q         <= ~sel_we;
                  we_q         <= sel_we;
                  state_q      <= ISSUE;
               end
            end

            ISSUE: begin
               tmo_cnt_q <= '0;
               state_q   <= BUSY;
            end

            // Ready still high after BUSY_TMO cycles means the controller completed at once.
            BUSY: begin
               if (!cur_rdy || tmo_cnt_q == TMO_LAST) begin
                  state_q <= DONE;
               end else if (tmo_cnt_q != 4'hF) begin
                  tmo_cnt_q <= tmo_cnt_q + 4'd1;
               end
            end

            DONE: begin
               if (cur_rdy) begin
                  if (gnt_port_q == PORT_A) begin
                     a_ack_q <= 1'b1;
                     if (!gnt_we_q) a_dout_q <= SDRAM_DOUT;
                  end else begin
                     b_ack_q <= 1'b1;
                     if (!gnt_we_q) b_dout_q <= SDRAM_DOUT;
                  end
                  state_q <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign A_ACK       = a_ack_q;
   assign B_ACK       = b_ack_q;
   assign A_DOUT      = a_dout_q;
   assign B_DOUT      = b_dout_q;
   assign SDRAM_RD    = rd_q;
   assign SDRAM_WE    = we_q;
   assign SDRAM_RADDR = gnt_addr_q;
   assign SDRAM_WADDR = gnt_addr_q;
   assign SDRAM_DIN   = gnt_din_q;
   assign SDRAM_BE    = gnt_be_q;

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter BUSY_TMO, default 8: cycles to wait for the controller to drop RDY after an issue before treating the access as already complete.
REQ-002 Parameter DATA_W, default 32: data width of the requester ports and of the SDRAM ports.
REQ-003 SDRAM_CLK  in  1  sole clock; all logic is on its rising edge.
REQ-004 SDRAM_RESn  in  1  reset; asynchronous assert, active-low.
REQ-005 A_REQ  in  1  port A (CPU memory interface) request level; A_WE, A_ADDR, A_DIN and A_BE are held stable while A_REQ=1.
REQ-006 A_WE  in  1  port A direction: 1=write, 0=read.
REQ-007 A_ADDR  in  25  port A word address.
REQ-008 A_DIN  in  DATA_W  port A write data.
REQ-009 A_BE  in  4  port A byte enables, active-high.
REQ-010 A_ACK  out  1  port A completion, one-cycle pulse.
REQ-011 A_DOUT  out  DATA_W  port A read data; valid from the cycle A_ACK=1 until the next port A read completes.
REQ-012 B_REQ, B_WE, B_ADDR, B_DIN, B_BE, B_ACK, B_DOUT: port B (DMA/video fetch), with widths and meanings identical to port A.
REQ-013 SDRAM_RD / SDRAM_WE  out  1 each  one-cycle command pulses to the SDRAM controller.
REQ-014 SDRAM_RADDR / SDRAM_WADDR  out  25 each; SDRAM_DIN  out  DATA_W; SDRAM_BE  out  4.
REQ-015 SDRAM_RD_RDY / SDRAM_WE_RDY  in  1 each  controller ready: low while busy, high when idle or complete.
REQ-016 SDRAM_DOUT  in  DATA_W  controller read data; valid while SDRAM_RD_RDY=1 after a read completes.

Function
REQ-017 FSM states: IDLE, ISSUE, BUSY, DONE.
REQ-018 IDLE -> ISSUE when a request is selected and the ready input for its direction is 1; otherwise stay in IDLE.
REQ-019 Request selection:
 - If only one REQ is high, that port is selected.
 - If both REQ are high, the port not granted last is selected (round-robin).
 - last_grant resets to B, so A wins the first tie.
REQ-020 Grant entry: on IDLE->ISSUE, latch the granted port ID, WE, ADDR, DIN and BE; update last_grant.
REQ-021 ISSUE, exactly one cycle:
 - read: SDRAM_RD=1; write: SDRAM_WE=1.
 - Address, data and byte enables come from the grant latch.
 - Both address outputs carry the latched address.
 - Next state is BUSY.
REQ-022 BUSY, relevant ready = SDRAM_RD_RDY for reads, SDRAM_WE_RDY for writes:
 - -> DONE when relevant ready=0.
 - -> DONE with the access taken as complete after BUSY_TMO cycles with relevant ready=1 (controller finished instantly).
REQ-023 DONE:
 - Wait for relevant ready=1.
 - In that cycle capture SDRAM_DOUT into the granted port's DOUT register (reads only).
 - Next state is IDLE; the granted port's ACK is registered high for the first IDLE cycle.
REQ-024 Fixed latencies:
 - REQ sampled in IDLE to SDRAM_RD/SDRAM_WE high: 1 cycle.
 - Ready return to ACK high: 1 cycle.
 - Minimum REQ-to-ACK: 4 cycles.
REQ-025 A port's REQ is ignored in the cycle its own ACK=1, so a requester drops REQ on seeing ACK; the other port may be granted in that cycle.
REQ-026 REQ dropped after grant: the access still completes and ACK still pulses; no abort exists.
REQ-027 Outputs when not in ISSUE: SDRAM_RD=0 and SDRAM_WE=0; address, data and byte-enable outputs hold their last values.
REQ-028 The BUSY timeout counter is 4 bits wide, clears on entry to BUSY, and saturates.
REQ-029 Write completion pulses ACK and leaves that port's DOUT unchanged.
REQ-030 Simultaneous new REQ on the non-granted port during ISSUE/BUSY/DONE waits; it is served in the next IDLE cycle.

Reset
REQ-031 While SDRAM_RESn=0:
 - State is IDLE and last_grant is B.
 - A_ACK, B_ACK, SDRAM_RD and SDRAM_WE are 0.
 - A_DOUT and B_DOUT are 0; all latched address, data and byte-enable registers are 0; the timeout counter is 0.
REQ-032 Reset mid-transaction abandons the access with no ACK; the bench treats the SDRAM contents as undefined.
REQ-033 Reset deassertion: the first grant is possible on the first rising edge after SDRAM_RESn=1.

Verification
REQ-034 A_REQ, read, A_ADDR=0x0800010, RD_RDY drops 2 cycles later and returns high with SDRAM_DOUT=0xDEADBEEF -> exactly one SDRAM_RD pulse with RADDR=0x0800010; A_ACK one cycle after RD_RDY rises; A_DOUT=0xDEADBEEF.
REQ-035 A_REQ and B_REQ both high in the same cycle after reset -> A served first, then B; next simultaneous pair -> A served first again, since B was granted last.
REQ-036 B write, B_BE=0x3, B_DIN=0x12345678; WE_RDY stays high (instant controller) -> SDRAM_WE pulse with SDRAM_BE=0x3; BUSY times out after 8 cycles; B_ACK pulses; B_DOUT unchanged.
REQ-037 RD_RDY=0 while A_REQ is high in IDLE -> no SDRAM_RD until RD_RDY=1; issue then occurs 1 cycle later.
REQ-038 SDRAM_RESn pulsed low during BUSY -> all outputs 0 immediately; no ACK; after release a new A read completes normally.
REQ-039 A holds A_REQ high through its ACK with B idle -> exactly one access per ACK; no duplicate SDRAM_RD in the ACK cycle.
